// File: rtl/router_fsm_pkg.sv
// ---------------------------------------------------------------------------
// router_fsm_pkg
// Shared types and default sizing for the 1x3 router packet-sequencing FSM.
//   state_t          : 3-bit binary state encoding (all eight codes used)
//   RF_NUM_PORTS     : number of destination FIFOs
//   RF_ADDR_W        : width of the header address field
//   RF_TIMEOUT_CYCLES: WAIT_TILL_EMPTY watchdog limit (ROUTER_FSM_TIMEOUT_EN)
// ---------------------------------------------------------------------------
package router_fsm_pkg;

    localparam int RF_NUM_PORTS      = 3;
    localparam int RF_ADDR_W         = 2;
    localparam int RF_TIMEOUT_CYCLES = 1023;

    typedef enum logic [2:0] {
        ST_DA  = 3'd0,  // decode address
        ST_LFD = 3'd1,  // load first data (header)
        ST_LD  = 3'd2,  // load payload data
        ST_LP  = 3'd3,  // load parity
        ST_CPE = 3'd4,  // check parity error
        ST_FFS = 3'd5,  // FIFO full stall
        ST_LAF = 3'd6,  // load after full
        ST_WTE = 3'd7   // wait till destination FIFO empty
    } state_t;

endpackage

// File: rtl/router_fsm.sv
// ---------------------------------------------------------------------------
// router_fsm
// Packet-sequencing controller for the 1x3 router. Decodes the header's
// destination and drives the state strobes consumed by the register datapath,
// the FIFO write enable and the source busy flag. All outputs are decoded
// from registered state only.
//
// Optional feature macro: ROUTER_FSM_TIMEOUT_EN
//   defined   : watchdog counter in WTE; after TIMEOUT_CYCLES cycles the FSM
//               returns to DA and o_timeout pulses for one cycle
//   undefined : WTE waits indefinitely, o_timeout tied 0
//
// Ports
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_packet_valid      source framing (header through last payload byte)
//   i_datain            header address bits, sampled in DA
//   i_fifo_full         selected destination FIFO full
//   i_fifo_empty        per-destination FIFO empty
//   i_soft_reset        per-destination soft reset
//   i_parity_done       from register block
//   i_low_packet_valid  from register block
//   o_detect_add, o_lfd_state, o_ld_state, o_laf_state, o_full_state,
//   o_rst_int_reg       state strobes
//   o_write_enb_reg     FIFO write enable
//   o_busy              source must hold data
//   o_dest_addr         latched destination address
//   o_timeout           watchdog abort pulse
// ---------------------------------------------------------------------------
module router_fsm
    import router_fsm_pkg::*;
#(
    parameter int NUM_PORTS      = RF_NUM_PORTS,
    parameter int ADDR_W         = RF_ADDR_W,
    parameter int TIMEOUT_CYCLES = RF_TIMEOUT_CYCLES
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_packet_valid,
    input  logic [ADDR_W-1:0]    i_datain,
    input  logic                 i_fifo_full,
    input  logic [NUM_PORTS-1:0] i_fifo_empty,
    input  logic [NUM_PORTS-1:0] i_soft_reset,
    input  logic                 i_parity_done,
    input  logic                 i_low_packet_valid,
    output logic                 o_detect_add,
    output logic                 o_lfd_state,
    output logic                 o_ld_state,
    output logic                 o_laf_state,
    output logic                 o_full_state,
    output logic                 o_rst_int_reg,
    output logic                 o_write_enb_reg,
    output logic                 o_busy,
    output logic [ADDR_W-1:0]    o_dest_addr,
    output logic                 o_timeout
);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_dest_addr;
    logic                w_addr_legal;
    logic                w_empty_in;
    logic                w_empty_dest;
    logic                w_soft_dest;
    logic                w_timeout_hit;
    logic                w_timeout_fire;

    // Per-port selects written as explicit compares so an out-of-range
    // address never indexes past the vectors.
    always_comb begin
        w_empty_in   = 1'b0;
        w_empty_dest = 1'b0;
        w_soft_dest  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (i_datain == ADDR_W'(i)) begin
                w_empty_in = i_fifo_empty[i];
            end
            if (r_dest_addr == ADDR_W'(i)) begin
                w_empty_dest = i_fifo_empty[i];
                w_soft_dest  = i_soft_reset[i];
            end
        end
    end

    assign w_addr_legal = (int'(i_datain) < NUM_PORTS);

`ifdef ROUTER_FSM_TIMEOUT_EN
    logic [9:0] r_wte_cnt;
    logic       r_timeout;

    // Counter holds the number of completed WTE cycles; it restarts on
    // every entry into WTE.
    assign w_timeout_hit = (r_state == ST_WTE) &&
                           (r_wte_cnt == 10'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wte_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_fire;
            if (r_state == ST_WTE && w_next == ST_WTE) begin
                r_wte_cnt <= r_wte_cnt + 10'd1;
            end else begin
                r_wte_cnt <= '0;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    // No watchdog in this build; the term below is constant false.
    assign w_timeout_hit = (TIMEOUT_CYCLES < 0);
    assign o_timeout     = 1'b0;
`endif

    always_comb begin
        w_next         = r_state;
        w_timeout_fire = 1'b0;
        case (r_state)
            ST_DA: begin
                if (i_packet_valid && w_addr_legal) begin
                    w_next = w_empty_in ? ST_LFD : ST_WTE;
                end
            end
            ST_LFD: w_next = ST_LD;
            ST_LD: begin
                if (i_fifo_full) begin
                    w_next = ST_FFS;
                end else if (!i_packet_valid) begin
                    w_next = ST_LP;
                end
            end
            ST_FFS: begin
                if (!i_fifo_full) begin
                    w_next = ST_LAF;
                end
            end
            ST_LAF: begin
                if (i_parity_done) begin
                    w_next = ST_DA;
                end else if (i_low_packet_valid) begin
                    w_next = ST_LP;
                end else begin
                    w_next = ST_LD;
                end
            end
            ST_LP:  w_next = ST_CPE;
            ST_CPE: w_next = i_fifo_full ? ST_FFS : ST_DA;
            ST_WTE: begin
                if (w_empty_dest) begin
                    w_next = ST_LFD;
                end else if (w_timeout_hit) begin
                    w_next         = ST_DA;
                    w_timeout_fire = 1'b1;
                end
            end
            default: w_next = ST_DA;
        endcase
        // Soft reset of the current destination overrides everything,
        // including a pending watchdog abort.
        if (w_soft_dest) begin
            w_next         = ST_DA;
            w_timeout_fire = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_DA;
            r_dest_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DA && i_packet_valid && w_addr_legal) begin
                r_dest_addr <= i_datain;
            end
        end
    end

    assign o_detect_add    = (r_state == ST_DA);
    assign o_lfd_state     = (r_state == ST_LFD);
    assign o_ld_state      = (r_state == ST_LD);
    assign o_laf_state     = (r_state == ST_LAF);
    assign o_full_state    = (r_state == ST_FFS);
    assign o_rst_int_reg   = (r_state == ST_CPE);
    assign o_write_enb_reg = (r_state == ST_LD) || (r_state == ST_LP) ||
                             (r_state == ST_LAF);
    assign o_busy          = (r_state == ST_LFD) || (r_state == ST_FFS) ||
                             (r_state == ST_LAF) || (r_state == ST_LP)  ||
                             (r_state == ST_CPE) || (r_state == ST_WTE);
    assign o_dest_addr     = r_dest_addr;

endmodule

// File: tb/tb_router_fsm.sv
// ---------------------------------------------------------------------------
// tb_router_fsm
// Directed packet scenarios with literal expectations, followed by a long
// randomized run. A phase-name reference model tracks where the controller
// must be and is compared against every DUT output on each falling edge.
// ---------------------------------------------------------------------------
module tb_router_fsm;

    localparam int NP = 3;
    localparam int AW = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          packet_valid;
    logic [AW-1:0] datain;
    logic          fifo_full;
    logic [NP-1:0] fifo_empty;
    logic [NP-1:0] soft_reset;
    logic          parity_done;
    logic          low_packet_valid;
    logic          detect_add, lfd_state, ld_state, laf_state, full_state;
    logic          rst_int_reg, write_enb_reg, busy, timeout;
    logic [AW-1:0] dest_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    router_fsm #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_packet_valid    (packet_valid),
        .i_datain          (datain),
        .i_fifo_full       (fifo_full),
        .i_fifo_empty      (fifo_empty),
        .i_soft_reset      (soft_reset),
        .i_parity_done     (parity_done),
        .i_low_packet_valid(low_packet_valid),
        .o_detect_add      (detect_add),
        .o_lfd_state       (lfd_state),
        .o_ld_state        (ld_state),
        .o_laf_state       (laf_state),
        .o_full_state      (full_state),
        .o_rst_int_reg     (rst_int_reg),
        .o_write_enb_reg   (write_enb_reg),
        .o_busy            (busy),
        .o_dest_addr       (dest_addr),
        .o_timeout         (timeout)
    );

    // ---------------- reference model (phase names) ----------------
`ifdef ROUTER_FSM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    string m_ph    = "DA";
    string m_nx;
    int    m_dest  = 0;
    int    m_nd;
    bit    m_to    = 1'b0;
    bit    m_nto;
    int    m_age   = 0;     // cycles spent in WTE so far, including current
    bit    m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_ph    = "DA";
            m_dest  = 0;
            m_to    = 1'b0;
            m_age   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_nx  = m_ph;
            m_nd  = m_dest;
            m_nto = 1'b0;
            if (m_ph == "DA") begin
                if (packet_valid && int'(datain) < NP) begin
                    m_nd = int'(datain);
                    m_nx = fifo_empty[datain] ? "LFD" : "WTE";
                end
            end else if (m_ph == "LFD") begin
                m_nx = "LD";
            end else if (m_ph == "LD") begin
                if (fifo_full) m_nx = "FFS";
                else if (!packet_valid) m_nx = "LP";
            end else if (m_ph == "FFS") begin
                if (!fifo_full) m_nx = "LAF";
            end else if (m_ph == "LAF") begin
                if (parity_done) m_nx = "DA";
                else if (low_packet_valid) m_nx = "LP";
                else m_nx = "LD";
            end else if (m_ph == "LP") begin
                m_nx = "CPE";
            end else if (m_ph == "CPE") begin
                m_nx = fifo_full ? "FFS" : "DA";
            end else if (m_ph == "WTE") begin
                if (fifo_empty[m_dest]) m_nx = "LFD";
                else if (TO_EN && m_age == TO) begin
                    m_nx  = "DA";
                    m_nto = 1'b1;
                end
            end
            if (soft_reset[m_dest]) begin
                m_nx  = "DA";
                m_nto = 1'b0;
            end
            if (m_nx == "WTE") m_age = (m_ph == "WTE") ? m_age + 1 : 1;
            else m_age = 0;
            m_ph   = m_nx;
            m_dest = m_nd;
            m_to   = m_nto;
        end
    end

    // Expected output bundle derived from the model phase:
    // {detect, lfd, ld, laf, full, rst_int, wen, busy, dest[1:0], timeout}
    function automatic logic [10:0] expected_bundle();
        logic wen, bsy;
        wen = (m_ph == "LD") || (m_ph == "LP") || (m_ph == "LAF");
        bsy = (m_ph != "DA") && (m_ph != "LD");
        return {m_ph == "DA", m_ph == "LFD", m_ph == "LD", m_ph == "LAF",
                m_ph == "FFS", m_ph == "CPE", wen, bsy, AW'(m_dest), m_to};
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            logic [10:0] act, exp_b;
            act = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   rst_int_reg, write_enb_reg, busy, dest_addr, timeout};
            exp_b = expected_bundle();
            checks++;
            if (act !== exp_b) begin
                failures++;
                $display("FAIL model_cmp t=%0t phase=%s actual=%b required=%b",
                         $time, m_ph, act, exp_b);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    initial begin
        reset            = 1'b1;
        packet_valid     = 1'b0;
        datain           = '0;
        fifo_full        = 1'b0;
        fifo_empty       = 3'b111;
        soft_reset       = '0;
        parity_done      = 1'b0;
        low_packet_valid = 1'b0;

        // 1: reset
        step(); step();
        chk("rst_detect", 32'(detect_add), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wen", 32'(write_enb_reg), 0);
        chk("rst_dest", 32'(dest_addr), 0);
        chk("rst_timeout", 32'(timeout), 0);

        // 2: packet to empty port 1, four payload bytes
        reset        = 1'b0;
        packet_valid = 1'b1;
        datain       = 2'b01;
        step();
        chk("p2_lfd", 32'(lfd_state), 1);
        chk("p2_lfd_busy", 32'(busy), 1);
        chk("p2_lfd_wen", 32'(write_enb_reg), 0);
        chk("p2_dest", 32'(dest_addr), 1);
        datain = AW'($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("p2_ld", 32'(ld_state), 1);
            chk("p2_ld_wen", 32'(write_enb_reg), 1);
        end
        packet_valid = 1'b0;
        step();
        chk("p2_lp_wen", 32'(write_enb_reg), 1);
        chk("p2_lp_busy", 32'(busy), 1);
        step();
        chk("p2_cpe_rst", 32'(rst_int_reg), 1);
        chk("p2_cpe_wen", 32'(write_enb_reg), 0);
        step();
        chk("p2_da", 32'(detect_add), 1);
        chk("p2_da_rst", 32'(rst_int_reg), 0);

        // 3: port 2 not empty for five cycles
        packet_valid = 1'b1;
        datain       = 2'b10;
        fifo_empty   = 3'b011;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("p3_wte_busy", 32'(busy), 1);
            chk("p3_wte_state", 32'({detect_add, lfd_state, write_enb_reg}), 0);
        end
        fifo_empty = 3'b111;
        step();
        chk("p3_lfd", 32'(lfd_state), 1);
        chk("p3_dest", 32'(dest_addr), 2);
        step();
        chk("p3_ld", 32'(ld_state), 1);

        // 4: FIFO full stall, then release with low_packet_valid
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("p4_ffs", 32'(full_state), 1);
            chk("p4_ffs_wen", 32'(write_enb_reg), 0);
        end
        fifo_full        = 1'b0;
        low_packet_valid = 1'b1;
        step();
        chk("p4_laf", 32'(laf_state), 1);
        chk("p4_laf_wen", 32'(write_enb_reg), 1);
        step();
        chk("p4_lp", 32'({ld_state, laf_state, write_enb_reg, busy}), 32'b0011);
        low_packet_valid = 1'b0;
        packet_valid     = 1'b0;
        step();
        chk("p4_cpe", 32'(rst_int_reg), 1);
        step();
        chk("p4_da", 32'(detect_add), 1);

        // 5: illegal address dropped; soft reset mid-packet
        packet_valid = 1'b1;
        datain       = 2'b11;
        step();
        chk("p5_illegal_da", 32'(detect_add), 1);
        chk("p5_illegal_wen", 32'(write_enb_reg), 0);
        chk("p5_illegal_dest", 32'(dest_addr), 2);
        datain = 2'b00;
        step();
        chk("p5_lfd", 32'(lfd_state), 1);
        step();
        chk("p5_ld", 32'(ld_state), 1);
        soft_reset = 3'b001;
        step();
        chk("p5_softrst_da", 32'(detect_add), 1);
        chk("p5_softrst_wen", 32'(write_enb_reg), 0);
        soft_reset   = '0;
        packet_valid = 1'b0;
        step();

`ifdef ROUTER_FSM_TIMEOUT_EN
        // 6: watchdog abort from WTE
        packet_valid = 1'b1;
        datain       = 2'b10;
        fifo_empty   = 3'b011;
        for (int i = 0; i < TO; i++) begin
            step();
            chk("p6_wte_busy", 32'(busy), 1);
            chk("p6_wte_to", 32'(timeout), 0);
        end
        packet_valid = 1'b0;
        step();
        chk("p6_to_da", 32'(detect_add), 1);
        chk("p6_to_pulse", 32'(timeout), 1);
        step();
        chk("p6_to_once", 32'(timeout), 0);
        fifo_empty = 3'b111;
`endif

        // Randomized run; the model compare covers every cycle.
        for (int n = 0; n < 4000; n++) begin
            reset            = ($urandom_range(0, 199) == 0);
            packet_valid     = ($urandom_range(0, 9) < 8);
            datain           = AW'($urandom_range(0, 3));
            fifo_full        = ($urandom_range(0, 4) == 0);
            fifo_empty       = NP'($urandom_range(0, 7));
            soft_reset       = ($urandom_range(0, 39) == 0) ? NP'($urandom_range(1, 7)) : '0;
            parity_done      = ($urandom_range(0, 3) == 0);
            low_packet_valid = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
